mask_win_ctrl: RTL and testbench
================================

// Module: mask_win_ctrl
// PURPOSE
// - Configuration/sequencing controller for the luma-threshold window mask stage: owns the
//   Y_0/x1_0/y1_0/x2_0/y2_0/del_x/del_y registers feeding the mask datapath.
// - CPU-side writes land in shadow regs; a commit request is validated, then applied only at the
//   next frame start, so the mask window never changes mid-frame.
// - Also counts mask=1 pixels per frame and reports the total at each frame boundary.
// PARAMETERS
// - Y0_DEF 64; X1_DEF 55; Y1_DEF 60; X2_DEF 660; Y2_DEF 192; DX_DEF 110; DY_DEF 10 : reset values
// - CNT_W 20 : width of the per-frame mask pixel counter (saturating)
// PORTS
// - clk        in   1      pixel clock, single clock domain
// - reset      in   1      synchronous, active-high
// - wr_en      in   1      config write strobe (one cycle per write)
// - wr_addr    in   3      0 Y_0, 1 x1, 2 y1, 3 x2, 4 y2, 5 del_x, 6 del_y, 7 commit request
// - wr_data    in   10     write data (Y_0 uses [7:0])
// - vsync      in   1      frame sync level from video timing; frame start = rising edge
// - mask_in    in   1      mask output of the datapath, same cycle as current pixel
// - Y_0,x1_0,y1_0,x2_0,y2_0,del_x,del_y  out  8/10  active window config to the mask datapath
// - busy       out  1      commit pending (accepted, waiting for frame start)
// - cfg_err    out  1      one-cycle pulse: commit rejected by validation
// - frame_done out  1      one-cycle pulse at each frame start
// - mask_count out  CNT_W  mask pixel total of the frame just ended, valid with frame_done, held
// BEHAVIOUR
// - Reset: active and shadow regs = *_DEF; busy=0, cfg_err=0, frame_done=0, mask_count=0,
//   counter=0, state=IDLE, vsync edge register=0.
// - Writes addr 0..6 update shadow only, any state; active outputs never change on a write.
// - FSM: IDLE -> CHECK on commit write (addr 7). CHECK (1 cycle) validates shadow:
//   x1+del_x <= x2-del_x AND y1+del_y <= y2-del_y AND x1<x2 AND y1<y2, 11-bit unsigned
//   math (no wrap). Pass -> PEND (busy=1). Fail -> cfg_err pulse, back to IDLE, active unchanged.
// - PEND -> APPLY on frame start; APPLY copies shadow->active in that cycle, outputs change the
//   next cycle (1-cycle latency after the vsync rise edge-detect), then -> IDLE, busy=0.
// - Shadow writes while in CHECK/PEND are legal; the value present at APPLY is what commits
//   (validated values may thus be overwritten: a write during PEND forces re-CHECK, returning
//   to CHECK, busy stays 1).
// - Commit write during CHECK/PEND: ignored beyond the re-CHECK rule above (no queueing).
// - Frame counter: increments on mask_in=1 each cycle, saturates at 2^CNT_W-1.
// - On frame start: mask_count <= counter value including current-cycle mask_in, frame_done=1
//   for one cycle, counter restarts at 0 (or 1 if mask_in=1 that cycle).
// - First frame start after reset reports the partial-frame count; consumers discard it.
// - Frame start coinciding with CHECK: commit waits for the next frame start (no same-cycle apply).
// - Reset mid-operation: pending commit dropped, shadow reverts to defaults.
// STRUCTURE
// - Shared package mask_pkg: address constants (A_Y0..A_COMMIT), default window constants,
//   FSM state enum {IDLE, CHECK, PEND, APPLY}, CNT_W.
// - One sub-module: mask_frame_cnt (vsync edge detect, saturating counter, mask_count/frame_done).
// - Remainder (shadow regs, validation, FSM) is flat in mask_win_ctrl.
// TESTING
// - Reset -> outputs 64/55/60/660/192/110/10, busy=0, mask_count=0, no pulses.
// - Write x1=100, x2=500, commit mid-frame -> busy=1, x1_0 stays 55 until vsync rise, then 100 one
//   cycle after, busy=0.
// - Write x1=400, x2=500 (del_x=110), commit -> cfg_err pulse 2 cycles after commit, x1_0 stays 55.
// - mask_in=1 for 1234 cycles in a frame -> at next vsync rise frame_done=1, mask_count=1234.
// - CNT_W=4, mask_in=1 for 40 cycles -> mask_count=15 (saturation).
// - Commit then write y2=300 during PEND, then vsync -> y2_0=300 applied; reset during PEND ->
//   defaults restored, busy=0, no apply at following vsync.

Source files
------------

// File: rtl/mask_pkg.sv
// Shared constants, state encoding and window validation helper for the
// luma-threshold window mask controller.
package mask_pkg;

   // Default width of the per-frame mask pixel counter
   localparam int CNT_W = 20;

   // Configuration register addresses
   localparam logic [2:0] A_Y0     = 3'd0;
   localparam logic [2:0] A_X1     = 3'd1;
   localparam logic [2:0] A_Y1     = 3'd2;
   localparam logic [2:0] A_X2     = 3'd3;
   localparam logic [2:0] A_Y2     = 3'd4;
   localparam logic [2:0] A_DX     = 3'd5;
   localparam logic [2:0] A_DY     = 3'd6;
   localparam logic [2:0] A_COMMIT = 3'd7;

   // Default window configuration
   localparam logic [7:0] DEF_Y0 = 8'd64;
   localparam logic [9:0] DEF_X1 = 10'd55;
   localparam logic [9:0] DEF_Y1 = 10'd60;
   localparam logic [9:0] DEF_X2 = 10'd660;
   localparam logic [9:0] DEF_Y2 = 10'd192;
   localparam logic [9:0] DEF_DX = 10'd110;
   localparam logic [9:0] DEF_DY = 10'd10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      PEND  = 2'd2,
      APPLY = 2'd3
   } win_state_t;

   // One axis of the window is usable when lo+del <= hi-del and lo < hi.
   // Evaluated in 11 bits; hi < del would underflow, so it is rejected outright.
   function automatic logic axis_ok(input logic [9:0] lo, input logic [9:0] hi,
                                    input logic [9:0] del);
      logic [10:0] lo_e;
      logic [10:0] hi_e;
      logic [10:0] del_e;
      lo_e  = {1'b0, lo};
      hi_e  = {1'b0, hi};
      del_e = {1'b0, del};
      axis_ok = (hi_e >= del_e) && ((lo_e + del_e) <= (hi_e - del_e)) && (lo_e < hi_e);
   endfunction

endpackage

// File: rtl/mask_frame_cnt.sv
// Frame-start detection and saturating per-frame count of mask=1 pixels.
// The total of the frame just ended is reported with a one-cycle frame_done pulse.
module mask_frame_cnt #(
   parameter int CNT_W = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             vsync,
   input  logic             mask_in,
   output logic             frame_start,
   output logic             frame_done,
   output logic [CNT_W-1:0] mask_count
);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             vsync_r;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_inc_s;

   // Rising edge of vsync marks the first cycle of a new frame
   assign frame_start = vsync & ~vsync_r;

   // Count including the current pixel, held at all-ones once saturated
   always_comb begin
      cnt_inc_s = cnt_r;
      if (mask_in && (cnt_r != CNT_MAX)) begin
         cnt_inc_s = cnt_r + CNT_ONE;
      end else begin
         cnt_inc_s = cnt_r;
      end
   end

   // Edge register, running counter and the frame-boundary report
   always_ff @(posedge clk) begin
      if (reset) begin
         vsync_r    <= 1'b0;
         cnt_r      <= CNT_ZERO;
         mask_count <= CNT_ZERO;
         frame_done <= 1'b0;
      end else begin
         vsync_r    <= vsync;
         frame_done <= frame_start;
         if (frame_start) begin
            mask_count <= cnt_inc_s;
            cnt_r      <= mask_in ? CNT_ONE : CNT_ZERO;
         end else begin
            cnt_r      <= cnt_inc_s;
         end
      end
   end

endmodule

// File: rtl/mask_win_ctrl.sv
// Window configuration controller for the mask stage. CPU writes land in
// shadow registers; a commit is validated and then applied only at the next
// frame start so the active window never changes mid-frame.
module mask_win_ctrl #(
   parameter int         CNT_W  = mask_pkg::CNT_W,
   parameter logic [7:0] Y0_DEF = 8'd64,
   parameter logic [9:0] X1_DEF = 10'd55,
   parameter logic [9:0] Y1_DEF = 10'd60,
   parameter logic [9:0] X2_DEF = 10'd660,
   parameter logic [9:0] Y2_DEF = 10'd192,
   parameter logic [9:0] DX_DEF = 10'd110,
   parameter logic [9:0] DY_DEF = 10'd10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [2:0]       wr_addr,
   input  logic [9:0]       wr_data,
   input  logic             vsync,
   input  logic             mask_in,
   output logic [7:0]       Y_0,
   output logic [9:0]       x1_0,
   output logic [9:0]       y1_0,
   output logic [9:0]       x2_0,
   output logic [9:0]       y2_0,
   output logic [9:0]       del_x,
   output logic [9:0]       del_y,
   output logic             busy,
   output logic             cfg_err,
   output logic             frame_done,
   output logic [CNT_W-1:0] mask_count
);

   import mask_pkg::*;

   win_state_t state_r;
   win_state_t state_nx_s;

   logic [7:0] sh_y0_r;
   logic [9:0] sh_x1_r, sh_y1_r, sh_x2_r, sh_y2_r, sh_dx_r, sh_dy_r;
   logic [7:0] act_y0_r;
   logic [9:0] act_x1_r, act_y1_r, act_x2_r, act_y2_r, act_dx_r, act_dy_r;
   logic       busy_r;
   logic       cfg_err_r;
   logic       frame_start_s;
   logic       cfg_wr_s;
   logic       commit_s;
   logic       shadow_ok_s;

   assign cfg_wr_s    = wr_en && (wr_addr != A_COMMIT);
   assign commit_s    = wr_en && (wr_addr == A_COMMIT);
   assign shadow_ok_s = axis_ok(sh_x1_r, sh_x2_r, sh_dx_r) && axis_ok(sh_y1_r, sh_y2_r, sh_dy_r);

   mask_frame_cnt #(
      .CNT_W (CNT_W)
   ) u_frame_cnt (
      .clk         (clk),
      .reset       (reset),
      .vsync       (vsync),
      .mask_in     (mask_in),
      .frame_start (frame_start_s),
      .frame_done  (frame_done),
      .mask_count  (mask_count)
   );

   // Commit sequencing; a config write while validating or pending forces a fresh check
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (commit_s) state_nx_s = CHECK;
            else          state_nx_s = IDLE;
         end
         CHECK: begin
            if (cfg_wr_s)         state_nx_s = CHECK;
            else if (shadow_ok_s) state_nx_s = PEND;
            else                  state_nx_s = IDLE;
         end
         PEND: begin
            if (cfg_wr_s)           state_nx_s = CHECK;
            else if (frame_start_s) state_nx_s = APPLY;
            else                    state_nx_s = PEND;
         end
         APPLY: begin
            state_nx_s = IDLE;
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_r <= IDLE;
      else       state_r <= state_nx_s;
   end

   // Busy flag and one-cycle rejection pulse from the validation verdict
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_r    <= 1'b0;
         cfg_err_r <= 1'b0;
      end else begin
         cfg_err_r <= 1'b0;
         case (state_r)
            CHECK: begin
               if (!cfg_wr_s) begin
                  busy_r    <= shadow_ok_s;
                  cfg_err_r <= ~shadow_ok_s;
               end else begin
                  busy_r    <= busy_r;
               end
            end
            APPLY:   busy_r <= 1'b0;
            default: busy_r <= busy_r;
         endcase
      end
   end

   // Shadow registers take CPU writes in any state
   always_ff @(posedge clk) begin
      if (reset) begin
         sh_y0_r <= Y0_DEF;
         sh_x1_r <= X1_DEF;
         sh_y1_r <= Y1_DEF;
         sh_x2_r <= X2_DEF;
         sh_y2_r <= Y2_DEF;
         sh_dx_r <= DX_DEF;
         sh_dy_r <= DY_DEF;
      end else if (cfg_wr_s) begin
         case (wr_addr)
            A_Y0:    sh_y0_r <= wr_data[7:0];
            A_X1:    sh_x1_r <= wr_data;
            A_Y1:    sh_y1_r <= wr_data;
            A_X2:    sh_x2_r <= wr_data;
            A_Y2:    sh_y2_r <= wr_data;
            A_DX:    sh_dx_r <= wr_data;
            A_DY:    sh_dy_r <= wr_data;
            default: sh_y0_r <= sh_y0_r;
         endcase
      end
   end

   // Active window is loaded from the shadow set only in the cycle after a frame start
   always_ff @(posedge clk) begin
      if (reset) begin
         act_y0_r <= Y0_DEF;
         act_x1_r <= X1_DEF;
         act_y1_r <= Y1_DEF;
         act_x2_r <= X2_DEF;
         act_y2_r <= Y2_DEF;
         act_dx_r <= DX_DEF;
         act_dy_r <= DY_DEF;
      end else if (state_r == APPLY) begin
         act_y0_r <= sh_y0_r;
         act_x1_r <= sh_x1_r;
         act_y1_r <= sh_y1_r;
         act_x2_r <= sh_x2_r;
         act_y2_r <= sh_y2_r;
         act_dx_r <= sh_dx_r;
         act_dy_r <= sh_dy_r;
      end
   end

   assign Y_0     = act_y0_r;
   assign x1_0    = act_x1_r;
   assign y1_0    = act_y1_r;
   assign x2_0    = act_x2_r;
   assign y2_0    = act_y2_r;
   assign del_x   = act_dx_r;
   assign del_y   = act_dy_r;
   assign busy    = busy_r;
   assign cfg_err = cfg_err_r;

endmodule

// File: tb/tb_mask_win_ctrl.sv
// Self-checking bench for mask_win_ctrl: a cycle model of the commit/apply
// rules and frame counting is compared with the DUT every cycle, plus
// hand-computed literal expectations at the key points.
module tb_mask_win_ctrl;

   logic        clk = 1'b0;
   logic        reset, wr_en, vsync, mask_in;
   logic [2:0]  wr_addr;
   logic [9:0]  wr_data;
   logic [7:0]  Y_0, y0_4;
   logic [9:0]  x1_0, y1_0, x2_0, y2_0, del_x, del_y;
   logic [9:0]  x1_4, y1_4, x2_4, y2_4, dx_4, dy_4;
   logic        busy, cfg_err, frame_done, busy_4, err_4, fd_4;
   logic [19:0] mask_count;
   logic [3:0]  mask_count4;

   int n_checks = 0;
   int n_fail   = 0;
   bit sim_done = 1'b0;

   localparam int MAX20 = 1048575;
   localparam int MAX4  = 15;

   // model state
   int dflt [7] = '{64, 55, 60, 660, 192, 110, 10};
   int sh [7];
   int act [7];
   bit vs_prev, e_fd, e_err, e_busy, verdict_due, waiting, apply_now;
   int cnt20, cnt4, e_mc, e_mc4;

   always #5 clk = ~clk;

   mask_win_ctrl dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .vsync(vsync), .mask_in(mask_in), .Y_0(Y_0), .x1_0(x1_0), .y1_0(y1_0),
      .x2_0(x2_0), .y2_0(y2_0), .del_x(del_x), .del_y(del_y), .busy(busy),
      .cfg_err(cfg_err), .frame_done(frame_done), .mask_count(mask_count)
   );

   mask_win_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .vsync(vsync), .mask_in(mask_in), .Y_0(y0_4), .x1_0(x1_4), .y1_0(y1_4),
      .x2_0(x2_4), .y2_0(y2_4), .del_x(dx_4), .del_y(dy_4), .busy(busy_4),
      .cfg_err(err_4), .frame_done(fd_4), .mask_count(mask_count4)
   );

   task automatic chk(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   // window is acceptable when both margins fit inside the extents (signed maths, no wrap)
   function automatic bit model_ok();
      return (sh[1] + sh[5] <= sh[3] - sh[5]) && (sh[2] + sh[6] <= sh[4] - sh[6]) &&
             (sh[1] < sh[3]) && (sh[2] < sh[4]);
   endfunction

   // advance the model by one clock edge, using the inputs present at that edge
   task automatic model_step();
      bit fs, cw, cm;
      int m;
      if (reset) begin
         for (int i = 0; i < 7; i++) begin
            sh[i]  = dflt[i];
            act[i] = dflt[i];
         end
         vs_prev = 1'b0; cnt20 = 0; cnt4 = 0; e_mc = 0; e_mc4 = 0;
         e_fd = 1'b0; e_err = 1'b0; e_busy = 1'b0;
         verdict_due = 1'b0; waiting = 1'b0; apply_now = 1'b0;
      end else begin
         m  = int'(mask_in);
         fs = vsync && !vs_prev;
         cw = wr_en && (wr_addr != 3'd7);
         cm = wr_en && (wr_addr == 3'd7);
         vs_prev = vsync;
         e_fd = fs;
         if (fs) begin
            e_mc  = sat(cnt20 + m, MAX20);
            e_mc4 = sat(cnt4 + m, MAX4);
            cnt20 = m;
            cnt4  = m;
         end else begin
            cnt20 = sat(cnt20 + m, MAX20);
            cnt4  = sat(cnt4 + m, MAX4);
         end
         e_err = 1'b0;
         if (apply_now) begin
            for (int i = 0; i < 7; i++) act[i] = sh[i];
            apply_now = 1'b0;
            e_busy    = 1'b0;
         end else if (verdict_due) begin
            if (!cw) begin
               verdict_due = 1'b0;
               if (model_ok()) begin
                  waiting = 1'b1;
                  e_busy  = 1'b1;
               end else begin
                  e_err  = 1'b1;
                  e_busy = 1'b0;
               end
            end
         end else if (waiting) begin
            if (cw) begin
               waiting     = 1'b0;
               verdict_due = 1'b1;
            end else if (fs) begin
               waiting   = 1'b0;
               apply_now = 1'b1;
            end
         end else if (cm) begin
            verdict_due = 1'b1;
         end
         if (cw) sh[int'(wr_addr)] = (wr_addr == 3'd0) ? int'(wr_data[7:0]) : int'(wr_data);
      end
   endtask

   // model update on every rising edge, comparison on the following falling edge
   initial begin
      forever begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         if (sim_done) break;
         chk("Y_0", int'(Y_0), act[0]);
         chk("x1_0", int'(x1_0), act[1]);
         chk("y1_0", int'(y1_0), act[2]);
         chk("x2_0", int'(x2_0), act[3]);
         chk("y2_0", int'(y2_0), act[4]);
         chk("del_x", int'(del_x), act[5]);
         chk("del_y", int'(del_y), act[6]);
         chk("busy", int'(busy), int'(e_busy));
         chk("cfg_err", int'(cfg_err), int'(e_err));
         chk("frame_done", int'(frame_done), int'(e_fd));
         chk("mask_count", int'(mask_count), e_mc);
         chk("mask_count4", int'(mask_count4), e_mc4);
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [2:0] a, input logic [9:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 10'd0;
      vsync = 1'b0; mask_in = 1'b0;
      cycles(3);
      reset = 1'b0;
      cycles(1);
      chk("rst_Y_0", int'(Y_0), 64);
      chk("rst_x1", int'(x1_0), 55);
      chk("rst_y1", int'(y1_0), 60);
      chk("rst_x2", int'(x2_0), 660);
      chk("rst_y2", int'(y2_0), 192);
      chk("rst_dx", int'(del_x), 110);
      chk("rst_dy", int'(del_y), 10);
      chk("rst_busy", int'(busy), 0);
      chk("rst_count", int'(mask_count), 0);
      chk("rst_fd", int'(frame_done), 0);
      chk("rst_err", int'(cfg_err), 0);

      // rejected commit: 400+110 > 500-110
      wr(3'd1, 10'd400); wr(3'd3, 10'd500); wr(3'd7, 10'd0);
      cycles(1);
      chk("rej_err", int'(cfg_err), 1);
      chk("rej_busy", int'(busy), 0);
      cycles(1);
      chk("rej_err_pulse", int'(cfg_err), 0);
      chk("rej_x1", int'(x1_0), 55);

      // accepted commit applied one cycle after the vsync rise
      wr(3'd1, 10'd100); wr(3'd7, 10'd0);
      cycles(1);
      chk("acc_busy", int'(busy), 1);
      cycles(5);
      chk("acc_hold_x1", int'(x1_0), 55);
      vsync = 1'b1;
      cycles(1);
      chk("acc_fd", int'(frame_done), 1);
      chk("acc_x1_pre", int'(x1_0), 55);
      cycles(1);
      chk("acc_x1", int'(x1_0), 100);
      chk("acc_x2", int'(x2_0), 500);
      chk("acc_busy_clr", int'(busy), 0);
      chk("acc_fd_pulse", int'(frame_done), 0);
      vsync = 1'b0;

      // 1234 mask pixels in one frame
      cycles(2);
      vsync = 1'b1; cycles(1); vsync = 1'b0;
      mask_in = 1'b1; cycles(1234); mask_in = 1'b0;
      cycles(3);
      vsync = 1'b1; cycles(1);
      chk("cnt_fd", int'(frame_done), 1);
      chk("cnt_1234", int'(mask_count), 1234);
      chk("cnt4_sat", int'(mask_count4), 15);
      vsync = 1'b0;

      // 40 pixels: 4-bit counter saturates at 15
      mask_in = 1'b1; cycles(40); mask_in = 1'b0;
      cycles(2);
      vsync = 1'b1; cycles(1);
      chk("cnt_40", int'(mask_count), 40);
      chk("cnt4_40", int'(mask_count4), 15);
      vsync = 1'b0;

      // mask_in in the frame-start cycle belongs to the ending frame and seeds the next
      cycles(2);
      mask_in = 1'b1; cycles(4);
      vsync = 1'b1; cycles(1);
      chk("cnt_edge5", int'(mask_count), 5);
      mask_in = 1'b0; vsync = 1'b0;
      cycles(2);
      vsync = 1'b1; cycles(1);
      chk("cnt_seed1", int'(mask_count), 1);
      vsync = 1'b0;

      // write during pending forces a re-check; the newest shadow value is applied
      cycles(2);
      wr(3'd7, 10'd0);
      cycles(2);
      chk("re_busy_pend", int'(busy), 1);
      wr(3'd4, 10'd300);
      chk("re_busy_chk", int'(busy), 1);
      cycles(1);
      chk("re_busy_ok", int'(busy), 1);
      chk("re_y2_hold", int'(y2_0), 192);
      cycles(2);
      vsync = 1'b1; cycles(2);
      chk("re_y2", int'(y2_0), 300);
      chk("re_busy_clr", int'(busy), 0);
      vsync = 1'b0;

      // reset while pending drops the commit
      cycles(2);
      wr(3'd3, 10'd600); wr(3'd7, 10'd0);
      cycles(2);
      chk("rp_busy", int'(busy), 1);
      reset = 1'b1; cycles(1); reset = 1'b0;
      chk("rp_x2", int'(x2_0), 660);
      chk("rp_x1", int'(x1_0), 55);
      chk("rp_y2", int'(y2_0), 192);
      chk("rp_busy_clr", int'(busy), 0);
      chk("rp_count", int'(mask_count), 0);
      cycles(2);
      vsync = 1'b1; cycles(3);
      chk("rp_no_apply_x2", int'(x2_0), 660);
      chk("rp_no_apply_busy", int'(busy), 0);
      vsync = 1'b0;
      cycles(2);

      sim_done = 1'b1;
      cycles(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
